multicycle_control_fsm: RTL and testbench

Multi-cycle control unit for the RISC-V core, the sequential successor to the single-cycle main decoder. It sequences each RV32I instruction through fetch, decode, execute, memory and writeback states over a shared instruction/data memory port. It waits on a memory ready handshake with an optional timeout, and traps on illegal opcodes. It drives the multi-cycle datapath's enables and mux selects.

---
 rtl/multicycle_control_fsm_if.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control FSM to datapath/memory signal bundle
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic [1:0] trap_cause;
  logic [3:0] state_o;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap_cause, state_o
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap_cause, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32I control FSM with memory wait timeout
module multicycle_control_fsm #(
  parameter int unsigned MAX_WAIT     = 16,
  parameter bit          ILLEGAL_TRAP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_control_fsm_if.master ctrl
);
  localparam int unsigned   CW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_AUIPC    = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  logic [3:0]    state;
  logic [3:0]    state_next;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    trap_cause_q;
  logic [1:0]    trap_next;
  logic          timeout;

  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ctrl.mem_ready;
        pc_write   = ctrl.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = ctrl.branch_taken;
      end
      // ALUOut already holds the jump target; the ALU now forms OldPC+4 for rd.
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ctrl.opcode)
      OP_STORE:         imm_src = 3'b001;
      OP_BRANCH:        imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
  end

  // A handshake completing in the limit cycle takes priority over the timeout.
  assign timeout = (MAX_WAIT != 0) && mem_req && !ctrl.mem_ready && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    state_next = state;
    trap_next  = trap_cause_q;
    case (state)
      S_FETCH: if (ctrl.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_next = S_TRAP;
              trap_next  = TC_ILLEGAL;
            end else begin
              state_next = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR:   state_next = (ctrl.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ctrl.mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (ctrl.mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_JALR:     state_next = S_JAL;
      S_LUI:      state_next = S_ALUWB;
      S_AUIPC:    state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
    if (timeout) begin
      state_next = S_TRAP;
      trap_next  = TC_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      trap_cause_q <= TC_NONE;
    end else begin
      state        <= state_next;
      trap_cause_q <= trap_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (mem_req && !ctrl.mem_ready && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign ctrl.pc_write   = pc_write;
  assign ctrl.ir_write   = ir_write;
  assign ctrl.adr_src    = adr_src;
  assign ctrl.mem_req    = mem_req;
  assign ctrl.mem_write  = mem_write;
  assign ctrl.reg_write  = reg_write;
  assign ctrl.result_src = result_src;
  assign ctrl.alu_src_a  = alu_src_a;
  assign ctrl.alu_src_b  = alu_src_b;
  assign ctrl.alu_op     = alu_op;
  assign ctrl.imm_src    = imm_src;
  assign ctrl.trap_cause = trap_cause_q;
  assign ctrl.state_o    = state;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed vector bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  multicycle_control_fsm_if ifa ();
  multicycle_control_fsm_if ifb ();
  multicycle_control_fsm_if ifc ();

  multicycle_control_fsm #(.MAX_WAIT(16), .ILLEGAL_TRAP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .ctrl(ifa));
  multicycle_control_fsm #(.MAX_WAIT(16), .ILLEGAL_TRAP(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .ctrl(ifb));
  multicycle_control_fsm #(.MAX_WAIT(4),  .ILLEGAL_TRAP(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .ctrl(ifc));

  logic [3:0]  st_v  [3];
  logic [18:0] ctl_v [3];
  assign st_v[0] = ifa.state_o;
  assign st_v[1] = ifb.state_o;
  assign st_v[2] = ifc.state_o;
  assign ctl_v[0] = {ifa.pc_write, ifa.ir_write, ifa.adr_src, ifa.mem_req, ifa.mem_write, ifa.reg_write,
                     ifa.result_src, ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op, ifa.imm_src, ifa.trap_cause};
  assign ctl_v[1] = {ifb.pc_write, ifb.ir_write, ifb.adr_src, ifb.mem_req, ifb.mem_write, ifb.reg_write,
                     ifb.result_src, ifb.alu_src_a, ifb.alu_src_b, ifb.alu_op, ifb.imm_src, ifb.trap_cause};
  assign ctl_v[2] = {ifc.pc_write, ifc.ir_write, ifc.adr_src, ifc.mem_req, ifc.mem_write, ifc.reg_write,
                     ifc.result_src, ifc.alu_src_a, ifc.alu_src_b, ifc.alu_op, ifc.imm_src, ifc.trap_cause};

  typedef struct {
    logic [6:0]  opcode;
    logic        bt;
    logic        mr;
    logic [3:0]  st;
    logic [18:0] ctl;
  } vec_t;
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // {pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, result_src, A, B, alu_op, imm_src, trap_cause}
  function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic adr, input logic req,
                                     input logic wr, input logic rw, input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op, input logic [2:0] imm,
                                     input logic [1:0] tc);
    return {pcw, irw, adr, req, wr, rw, rs, a, b, op, imm, tc};
  endfunction

  function automatic logic [18:0] c_fetch(input logic mr, input logic [2:0] imm);
    return mk(mr, mr, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 2'b00);
  endfunction

  function automatic logic [18:0] c_dec(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 2'b00);
  endfunction

  function automatic logic [18:0] c_wb(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 2'b00);
  endfunction

  task automatic add(input logic [6:0] op, input logic bt, input logic mr, input logic [3:0] st,
                     input logic [18:0] ctl);
    vec_t v;
    v.opcode = op; v.bt = bt; v.mr = mr; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step(input int d, input logic [3:0] st, input logic [18:0] ctl, input bit chk_ctl,
                      input string name);
    #1;
    check({name, " state"}, {28'd0, st_v[d]}, {28'd0, st});
    if (chk_ctl) check({name, " ctl"}, {13'd0, ctl_v[d]}, {13'd0, ctl});
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [18:0] trap_ill;
    logic [18:0] trap_to;
    logic [18:0] mrd;
    logic [18:0] mwb;
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    ifa.opcode = OP_R; ifa.branch_taken = 1'b0; ifa.mem_ready = 1'b0;
    ifb.opcode = OP_R; ifb.branch_taken = 1'b0; ifb.mem_ready = 1'b1;
    ifc.opcode = OP_R; ifc.branch_taken = 1'b0; ifc.mem_ready = 1'b1;
    trap_ill = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
    trap_to  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10);
    mrd      = mk(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    mwb      = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);

    add(OP_R, 0, 1, 4'd0, c_fetch(1, 3'b000));
    add(OP_R, 0, 1, 4'd1, c_dec(3'b000));
    add(OP_R, 0, 1, 4'd6, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    add(OP_R, 0, 1, 4'd8, c_wb(3'b000));
    add(OP_I, 0, 0, 4'd0, c_fetch(0, 3'b000));
    add(OP_I, 0, 1, 4'd0, c_fetch(1, 3'b000));
    add(OP_I, 0, 1, 4'd1, c_dec(3'b000));
    add(OP_I, 0, 1, 4'd7, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 2'b00));
    add(OP_I, 0, 1, 4'd8, c_wb(3'b000));
    add(OP_LUI, 0, 1, 4'd0, c_fetch(1, 3'b100));
    add(OP_LUI, 0, 1, 4'd1, c_dec(3'b100));
    add(OP_LUI, 0, 1, 4'd12, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, 3'b100, 2'b00));
    add(OP_LUI, 0, 1, 4'd8, c_wb(3'b100));
    add(OP_AUIPC, 0, 1, 4'd0, c_fetch(1, 3'b100));
    add(OP_AUIPC, 0, 0, 4'd1, c_dec(3'b100));
    add(OP_AUIPC, 0, 0, 4'd13, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100, 2'b00));
    add(OP_AUIPC, 0, 0, 4'd8, c_wb(3'b100));
    add(OP_LOAD, 0, 1, 4'd0, c_fetch(1, 3'b000));
    add(OP_LOAD, 0, 1, 4'd1, c_dec(3'b000));
    add(OP_LOAD, 0, 1, 4'd2, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00));
    for (int k = 0; k < 3; k++) add(OP_LOAD, 0, 0, 4'd3, mrd);
    add(OP_LOAD, 0, 1, 4'd3, mrd);
    add(OP_LOAD, 0, 1, 4'd4, mwb);
    add(OP_STORE, 0, 1, 4'd0, c_fetch(1, 3'b001));
    add(OP_STORE, 0, 1, 4'd1, c_dec(3'b001));
    add(OP_STORE, 0, 1, 4'd2, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 2'b00));
    add(OP_STORE, 0, 1, 4'd5, mk(0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00));
    add(OP_BRANCH, 1, 1, 4'd0, c_fetch(1, 3'b010));
    add(OP_BRANCH, 1, 1, 4'd1, c_dec(3'b010));
    add(OP_BRANCH, 1, 1, 4'd9, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 2'b00));
    add(OP_BRANCH, 0, 1, 4'd0, c_fetch(1, 3'b010));
    add(OP_BRANCH, 0, 1, 4'd1, c_dec(3'b010));
    add(OP_BRANCH, 0, 1, 4'd9, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 2'b00));
    add(OP_JALR, 0, 1, 4'd0, c_fetch(1, 3'b000));
    add(OP_JALR, 0, 1, 4'd1, c_dec(3'b000));
    add(OP_JALR, 0, 1, 4'd11, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00));
    add(OP_JALR, 0, 1, 4'd10, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00));
    add(OP_JALR, 0, 1, 4'd8, c_wb(3'b000));
    add(OP_JAL, 0, 1, 4'd0, c_fetch(1, 3'b011));
    add(OP_JAL, 0, 1, 4'd1, c_dec(3'b011));
    add(OP_JAL, 0, 1, 4'd10, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011, 2'b00));
    add(OP_JAL, 0, 1, 4'd8, c_wb(3'b011));
    add(OP_R, 0, 0, 4'd0, c_fetch(0, 3'b000));

    repeat (2) @(negedge clk);
    #1;
    check("reset state a", {28'd0, st_v[0]}, 32'd0);
    check("reset state c", {28'd0, st_v[2]}, 32'd0);
    check("reset ctl a", {13'd0, ctl_v[0]}, {13'd0, c_fetch(0, 3'b000)});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ifa.opcode       = vecs[i].opcode;
      ifa.branch_taken = vecs[i].bt;
      ifa.mem_ready    = vecs[i].mr;
      step(0, vecs[i].st, vecs[i].ctl, 1'b1, $sformatf("vec%0d", i));
    end

    ifa.opcode = 7'b0000000; ifa.mem_ready = 1'b1;
    reset_pulse();
    step(0, 4'd0, c_fetch(1, 3'b000), 1'b1, "illegal fetch");
    step(0, 4'd1, c_dec(3'b000), 1'b1, "illegal decode");
    for (int k = 0; k < 21; k++) step(0, 4'd14, trap_ill, 1'b1, $sformatf("illegal trap hold%0d", k));

    ifb.opcode = 7'b0000000; ifb.mem_ready = 1'b1;
    reset_pulse();
    step(1, 4'd0, c_fetch(1, 3'b000), 1'b1, "skip fetch");
    step(1, 4'd1, c_dec(3'b000), 1'b1, "skip decode");
    step(1, 4'd0, c_fetch(1, 3'b000), 1'b1, "skip back to fetch");

    ifc.opcode = OP_LOAD; ifc.mem_ready = 1'b0;
    reset_pulse();
    for (int k = 0; k < 5; k++) step(2, 4'd0, c_fetch(0, 3'b000), 1'b1, $sformatf("timeout fetch%0d", k));
    step(2, 4'd14, trap_to, 1'b1, "timeout trap");
    step(2, 4'd14, trap_to, 1'b1, "timeout trap hold");
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset state", {28'd0, st_v[2]}, 32'd0);
    check("async reset ctl", {13'd0, ctl_v[2]}, {13'd0, c_fetch(0, 3'b000)});
    @(negedge clk);
    rst_n = 1'b1;

    ifc.opcode = OP_LOAD; ifc.mem_ready = 1'b0;
    reset_pulse();
    for (int k = 0; k < 4; k++) step(2, 4'd0, c_fetch(0, 3'b000), 1'b1, $sformatf("limit fetch%0d", k));
    ifc.mem_ready = 1'b1;
    step(2, 4'd0, c_fetch(1, 3'b000), 1'b1, "limit fetch ready");
    ifc.mem_ready = 1'b0;
    step(2, 4'd1, c_dec(3'b000), 1'b1, "limit decode");
    step(2, 4'd2, 19'd0, 1'b0, "limit memadr");
    for (int k = 0; k < 4; k++) step(2, 4'd3, mrd, 1'b1, $sformatf("limit memread%0d", k));
    ifc.mem_ready = 1'b1;
    step(2, 4'd3, mrd, 1'b1, "limit memread ready");
    step(2, 4'd4, mwb, 1'b1, "limit memwb");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
